// File: rtl/icache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// icache_fill_ctrl
// Miss-handling fill controller for a 2-way, 64-set instruction cache with
// 16-byte blocks (eight 16-bit words). A miss latches tag/set/victim way, then
// eight word reads are streamed to a pipelined memory. Each returned word is
// written into the selected way's data array; the last word also writes the
// tag metadata and pulses fill_done.
//
// Ports
//   clk             in   clock, rising edge
//   rst             in   synchronous reset, active low
//   miss_detected   in   fetch miss, sampled only when idle
//   miss_address    in   [15:0] missing address (tag 15:10, set 9:4, word 3:1)
//   fill_way        in   victim way: 0 = way 1, 1 = way 2
//   mem_data_valid  in   memory returns one word this cycle
//   mem_data        in   [15:0] returned word
//   mem_en          out  read request this cycle
//   mem_addr        out  [15:0] request address
//   fill_busy       out  fill in progress, fetch must stall
//   fill_done       out  pulse with the last data word and metadata write
//   metaIn          out  [7:0] {valid, lru, tag}
//   dataIn          out  [15:0] word written to the data array
//   blockEn         out  [63:0] one-hot set select
//   wordEn          out  [7:0] one-hot word select
//   metaWrite1/2    out  metadata write strobe, way 1 / way 2
//   dataWrite1/2    out  data write strobe, way 1 / way 2
// -----------------------------------------------------------------------------
module icache_fill_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic        fill_way,
  input  logic        mem_data_valid,
  input  logic [15:0] mem_data,
  output logic        mem_en,
  output logic [15:0] mem_addr,
  output logic        fill_busy,
  output logic        fill_done,
  output logic [7:0]  metaIn,
  output logic [15:0] dataIn,
  output logic [63:0] blockEn,
  output logic [7:0]  wordEn,
  output logic        metaWrite1,
  output logic        metaWrite2,
  output logic        dataWrite1,
  output logic        dataWrite2
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] tag_q, tag_d;
  logic [5:0] set_q, set_d;
  logic       way_q, way_d;
  logic [3:0] req_cnt_q, req_cnt_d;
  logic [3:0] rsp_cnt_q, rsp_cnt_d;

  logic issue;
  logic last_word;
  logic unused_addr_bits;

  // Word offset and byte bit of the miss address do not matter: the whole
  // block is always fetched starting from word 0.
  assign unused_addr_bits = ^miss_address[3:0];

  // Requests are issued back to back until all eight have gone out; the
  // memory never stalls so no handshake is needed.
  assign issue     = (state_q == FILL) && (req_cnt_q < 4'd8);
  // Responses come back in request order, so the eighth response is the last
  // word regardless of latency.
  assign last_word = (state_q == FILL) && mem_data_valid && (rsp_cnt_q == 4'd7);

  // State and latch registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      tag_q     <= 6'd0;
      set_q     <= 6'd0;
      way_q     <= 1'b0;
      req_cnt_q <= 4'd0;
      rsp_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      tag_q     <= tag_d;
      set_q     <= set_d;
      way_q     <= way_d;
      req_cnt_q <= req_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
    end
  end

  // Next-state logic: accept a miss when idle, count requests and responses
  // while filling, return to idle on the last word.
  always_comb begin
    state_d   = state_q;
    tag_d     = tag_q;
    set_d     = set_q;
    way_d     = way_q;
    req_cnt_d = req_cnt_q;
    rsp_cnt_d = rsp_cnt_q;
    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          state_d   = FILL;
          tag_d     = miss_address[15:10];
          set_d     = miss_address[9:4];
          way_d     = fill_way;
          req_cnt_d = 4'd0;
          rsp_cnt_d = 4'd0;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        // miss_detected is deliberately ignored here; fetch re-presents it.
        if (issue) begin
          req_cnt_d = req_cnt_q + 4'd1;
        end else begin
          req_cnt_d = req_cnt_q;
        end
        if (mem_data_valid) begin
          rsp_cnt_d = rsp_cnt_q + 4'd1;
        end else begin
          rsp_cnt_d = rsp_cnt_q;
        end
        if (last_word) begin
          state_d = IDLE;
        end else begin
          state_d = FILL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode: everything is zero while idle; in FILL the request side
  // depends on registers only, the write side also on mem_data_valid.
  always_comb begin
    mem_en     = 1'b0;
    mem_addr   = 16'd0;
    fill_busy  = 1'b0;
    fill_done  = 1'b0;
    metaIn     = 8'd0;
    dataIn     = 16'd0;
    blockEn    = 64'd0;
    wordEn     = 8'd0;
    metaWrite1 = 1'b0;
    metaWrite2 = 1'b0;
    dataWrite1 = 1'b0;
    dataWrite2 = 1'b0;
    case (state_q)
      FILL: begin
        fill_busy = 1'b1;
        blockEn   = 64'd1 << set_q;
        if (issue) begin
          mem_en   = 1'b1;
          mem_addr = {tag_q, set_q, req_cnt_q[2:0], 1'b0};
        end else begin
          mem_en   = 1'b0;
          mem_addr = 16'd0;
        end
        if (mem_data_valid) begin
          dataIn     = mem_data;
          wordEn     = 8'd1 << rsp_cnt_q[2:0];
          dataWrite1 = ~way_q;
          dataWrite2 = way_q;
        end else begin
          dataIn = 16'd0;
          wordEn = 8'd0;
        end
        if (last_word) begin
          fill_done  = 1'b1;
          metaIn     = {1'b1, 1'b0, tag_q};
          metaWrite1 = ~way_q;
          metaWrite2 = way_q;
        end else begin
          fill_done = 1'b0;
        end
      end
      IDLE: begin
        fill_busy = 1'b0;
      end
      default: begin
        fill_busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for icache_fill_ctrl. A memory model answers the
// expected request stream (fixed 4-cycle latency or random gaps), and a
// reference model derives every cycle's expected outputs from the fill's
// cycle index and the count of words returned so far.
// -----------------------------------------------------------------------------
module tb_icache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        fill_way;
  logic        mem_data_valid;
  logic [15:0] mem_data;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic        fill_busy;
  logic        fill_done;
  logic [7:0]  metaIn;
  logic [15:0] dataIn;
  logic [63:0] blockEn;
  logic [7:0]  wordEn;
  logic        metaWrite1, metaWrite2, dataWrite1, dataWrite2;

  always #5 clk = ~clk;

  icache_fill_ctrl dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .fill_way(fill_way), .mem_data_valid(mem_data_valid), .mem_data(mem_data),
    .mem_en(mem_en), .mem_addr(mem_addr), .fill_busy(fill_busy), .fill_done(fill_done),
    .metaIn(metaIn), .dataIn(dataIn), .blockEn(blockEn), .wordEn(wordEn),
    .metaWrite1(metaWrite1), .metaWrite2(metaWrite2),
    .dataWrite1(dataWrite1), .dataWrite2(dataWrite2)
  );

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        men;
    logic [15:0] maddr;
    logic        mw1;
    logic        mw2;
    logic        dw1;
    logic        dw2;
    logic [7:0]  we;
    logic [15:0] din;
    logic [7:0]  min;
    logic [63:0] ben;
  } outv_t;

  outv_t obs_q[$];
  outv_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  function automatic outv_t sample_out();
    outv_t s;
    s.busy = fill_busy;   s.done = fill_done;  s.men = mem_en;    s.maddr = mem_addr;
    s.mw1  = metaWrite1;  s.mw2  = metaWrite2; s.dw1 = dataWrite1; s.dw2  = dataWrite2;
    s.we   = wordEn;      s.din  = dataIn;     s.min = metaIn;    s.ben   = blockEn;
    return s;
  endfunction

  // Expected outputs in fill cycle k (1 = first cycle after the miss edge)
  // when j words have already been returned and v says a word arrives now.
  function automatic outv_t fill_vec(input logic [15:0] base, input logic way, input int k,
                                     input logic v, input int j, input logic [15:0] d);
    outv_t e;
    logic  last;
    e      = '0;
    last   = v && (j == 7);
    e.busy = 1'b1;
    e.done = last;
    e.men  = (k <= 8);
    if (k <= 8) e.maddr = base + 16'(2 * (k - 1));
    e.dw1  = v && !way;
    e.dw2  = v && way;
    e.mw1  = last && !way;
    e.mw2  = last && way;
    if (v) begin
      e.we  = 8'(1 << j);
      e.din = d;
    end
    if (last) e.min = {2'b10, base[15:10]};
    e.ben = 64'd1 << base[9:4];
    return e;
  endfunction

  task automatic idle_cycles(input int n, input bit spurious);
    for (int i = 0; i < n; i++) begin
      rst            = 1'b1;
      miss_detected  = 1'b0;
      miss_address   = 16'($urandom);
      fill_way       = 1'($urandom_range(0, 1));
      mem_data_valid = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_data       = 16'($urandom);
      @(negedge clk);
      obs_q.push_back(sample_out());
      exp_q.push_back('0);
      @(posedge clk); #1;
    end
  endtask

  // One complete miss: cycle 0 raises the miss, then the memory model answers
  // the requested words. abort_after>0 pulls rst low in the cycle after that
  // many words; remiss raises a different miss mid-fill.
  task automatic drive_fill(input logic [15:0] addr, input logic way, input logic [15:0] dbase,
                            input bit jitter, input bit remiss, input int abort_after);
    logic [15:0] base;
    int          pend_word[$];
    int          pend_cyc[$];
    int          k, nval, next_ok, w;
    bit          in_fill, rst_now;
    logic        v;
    logic [15:0] d;
    outv_t       e, o;
    base    = {addr[15:4], 4'h0};
    nval    = 0;
    next_ok = 0;
    in_fill = 1'b1;
    rst            = 1'b1;
    miss_detected  = 1'b1;
    miss_address   = addr;
    fill_way       = way;
    mem_data_valid = 1'($urandom_range(0, 1));
    mem_data       = 16'($urandom);
    @(negedge clk);
    obs_q.push_back(sample_out());
    exp_q.push_back('0);
    @(posedge clk); #1;
    k = 1;
    while (in_fill || pend_word.size() > 0) begin
      if (k > 200) begin
        n_tests++; n_fail++;
        $display("FAIL fill_timeout: fill still open after %0d cycles, required at most 200", k);
        break;
      end
      v = 1'b0;
      d = 16'd0;
      if (pend_word.size() > 0 && pend_cyc[0] + (jitter ? 1 : 4) <= k && k >= next_ok) begin
        v = 1'b1;
        w = pend_word.pop_front();
        void'(pend_cyc.pop_front());
        d = dbase + 16'(w);
        if (jitter) next_ok = k + 1 + int'($urandom_range(0, 3));
      end
      rst_now        = in_fill && (abort_after > 0) && (nval == abort_after);
      rst            = !rst_now;
      miss_detected  = remiss && in_fill && (k >= 2) && (k <= 6);
      miss_address   = addr ^ 16'hF0F2;
      fill_way       = ~way;
      mem_data_valid = v;
      mem_data       = v ? d : 16'($urandom);
      e = in_fill ? fill_vec(base, way, k, v, nval, d) : outv_t'('0);
      @(negedge clk);
      o = sample_out();
      if (in_fill) begin
        // Fields not qualified by a strobe are don't-care during a fill.
        if (!e.men) o.maddr = 16'd0;
        if (!v) begin
          o.we  = 8'd0;
          o.din = 16'd0;
        end
        if (!(v && nval == 7)) o.min = 8'd0;
      end
      obs_q.push_back(o);
      exp_q.push_back(e);
      if (in_fill && k <= 8) begin
        pend_word.push_back(k - 1);
        pend_cyc.push_back(k);
      end
      if (in_fill && v) begin
        nval++;
        if (nval == 8) in_fill = 1'b0;
      end
      if (rst_now) in_fill = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    rst            = 1'b1;
    miss_detected  = 1'b0;
    mem_data_valid = 1'b0;
  endtask

  task automatic test_reset();
    obs_q.delete(); exp_q.delete();
    rst = 1'b0; miss_detected = 1'b1; miss_address = 16'h1234; fill_way = 1'b1;
    mem_data_valid = 1'b1; mem_data = 16'hBEEF;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      obs_q.push_back(sample_out());
      exp_q.push_back('0);
      @(posedge clk); #1;
    end
    idle_cycles(2, 1'b1);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL reset cycle %0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_basic_way1();
    int na, nd, nm, ndone, nw2;
    obs_q.delete(); exp_q.delete();
    drive_fill(16'h1A36, 1'b0, 16'hA000, 1'b0, 1'b0, 0);
    idle_cycles(1, 1'b0);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL basic_way1 cycle %0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    na = 0; nd = 0; nm = 0; ndone = 0; nw2 = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      if (obs_q[i].men) begin
        n_tests++;
        if (obs_q[i].maddr !== 16'h1A30 + 16'(2 * na)) begin
          n_fail++;
          $display("FAIL basic_way1 addr %0d: got %h required %h", na, obs_q[i].maddr, 16'h1A30 + 16'(2 * na));
        end
        na++;
      end
      if (obs_q[i].dw1) begin
        n_tests++;
        if (obs_q[i].din !== 16'hA000 + 16'(nd) || obs_q[i].we !== 8'(1 << nd) || obs_q[i].ben[35] !== 1'b1) begin
          n_fail++;
          $display("FAIL basic_way1 word %0d: got din %h wordEn %h required din %h wordEn %h set35",
                   nd, obs_q[i].din, obs_q[i].we, 16'hA000 + 16'(nd), 8'(1 << nd));
        end
        nd++;
      end
      if (obs_q[i].mw1) begin
        n_tests++;
        if (obs_q[i].min !== 8'h86 || nd !== 8) begin
          n_fail++;
          $display("FAIL basic_way1 meta: got metaIn %h at word %0d required 86 at word 8", obs_q[i].min, nd);
        end
        nm++;
      end
      if (obs_q[i].done) ndone++;
      if (obs_q[i].dw2 || obs_q[i].mw2) nw2++;
    end
    n_tests++;
    if (na !== 8 || nd !== 8 || nm !== 1 || ndone !== 1 || nw2 !== 0) begin
      n_fail++;
      $display("FAIL basic_way1 counts: got req %0d data %0d meta %0d done %0d way2 %0d required 8 8 1 1 0",
               na, nd, nm, ndone, nw2);
    end
  endtask

  task automatic test_way2_set63();
    int nw1, nm2;
    obs_q.delete(); exp_q.delete();
    drive_fill(16'hFFF0, 1'b1, 16'($urandom), 1'b0, 1'b0, 0);
    idle_cycles(1, 1'b0);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL way2_set63 cycle %0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    nw1 = 0; nm2 = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      if (obs_q[i].dw1 || obs_q[i].mw1) nw1++;
      if (obs_q[i].mw2) begin
        nm2++;
        n_tests++;
        if (obs_q[i].min !== 8'hBF || obs_q[i].ben !== 64'h8000_0000_0000_0000) begin
          n_fail++;
          $display("FAIL way2_set63 meta: got metaIn %h blockEn %h required BF 8000000000000000",
                   obs_q[i].min, obs_q[i].ben);
        end
      end
    end
    n_tests++;
    if (nw1 !== 0 || nm2 !== 1) begin
      n_fail++;
      $display("FAIL way2_set63 strobes: got way1 %0d meta2 %0d required 0 1", nw1, nm2);
    end
  endtask

  task automatic test_irregular();
    int nd, ndone;
    obs_q.delete(); exp_q.delete();
    for (int f = 0; f < 3; f++) begin
      drive_fill(16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom), 1'b1, 1'b0, 0);
      idle_cycles(int'($urandom_range(1, 2)), 1'b0);
    end
    nd = 0; ndone = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL irregular cycle %0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i].dw1 || obs_q[i].dw2) nd++;
      if (obs_q[i].done) ndone++;
    end
    n_tests++;
    if (nd !== 24 || ndone !== 3) begin
      n_fail++;
      $display("FAIL irregular counts: got writes %0d done %0d required 24 3", nd, ndone);
    end
  endtask

  task automatic test_ignored();
    obs_q.delete(); exp_q.delete();
    idle_cycles(5, 1'b1);
    drive_fill(16'h5A5E, 1'b0, 16'($urandom), 1'b0, 1'b1, 0);
    idle_cycles(4, 1'b1);
    drive_fill(16'h0F08, 1'b1, 16'($urandom), 1'b1, 1'b1, 0);
    idle_cycles(2, 1'b1);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ignored_inputs cycle %0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midfill();
    int nmeta, seg;
    obs_q.delete(); exp_q.delete();
    drive_fill(16'h3C48, 1'b0, 16'($urandom), 1'b0, 1'b0, 3);
    idle_cycles(2, 1'b1);
    seg = obs_q.size();
    drive_fill(16'h3C48, 1'b1, 16'($urandom), 1'b0, 1'b0, 0);
    idle_cycles(1, 1'b0);
    nmeta = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL reset_midfill cycle %0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
      if (i < seg && (obs_q[i].mw1 || obs_q[i].mw2 || obs_q[i].done)) nmeta++;
    end
    n_tests++;
    if (nmeta !== 0) begin
      n_fail++;
      $display("FAIL reset_midfill meta: got %0d metadata writes in aborted fill required 0", nmeta);
    end
  endtask

  task automatic test_back_to_back();
    obs_q.delete(); exp_q.delete();
    drive_fill(16'h2468, 1'b0, 16'($urandom), 1'b0, 1'b0, 0);
    drive_fill(16'hC3A2, 1'b1, 16'($urandom), 1'b0, 1'b0, 0);
    drive_fill(16'h7E5C, 1'b0, 16'($urandom), 1'b1, 1'b0, 0);
    idle_cycles(1, 1'b0);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    obs_q.delete(); exp_q.delete();
    for (int f = 0; f < 6; f++) begin
      drive_fill(16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      idle_cycles(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    rst            = 1'b0;
    miss_detected  = 1'b0;
    miss_address   = 16'd0;
    fill_way       = 1'b0;
    mem_data_valid = 1'b0;
    mem_data       = 16'd0;
    test_reset();
    test_basic_way1();
    test_way2_set63();
    test_irregular();
    test_ignored();
    test_reset_midfill();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_fill_ctrl.md
# icache_fill_ctrl

Miss-handling fill controller for the 2-way, 64-set instruction cache (16-byte blocks, eight 16-bit words). On a miss it latches the miss address and victim way, then issues eight word reads to the pipelined main memory. Each returned word is written into the cache data array, and on the last word the tag metadata is written. It is the writer that drives the cache's `metaIn`/`dataIn`/`blockEn`/`wordEn`/write-enable inputs and sits between the fetch stage's miss detect and memory.

## Interface
- No parameters. Geometry is fixed:
  - 16-bit address; tag = addr[15:10]; set = addr[9:4]; word = addr[3:1]; addr[0] ignored.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- miss_detected  in  1  fetch reports a miss; sampled only in IDLE.
- miss_address  in  16  missing fetch address; sampled with miss_detected.
- fill_way  in  1  victim way, sampled with miss_detected: 0 = way 1, 1 = way 2.
- mem_data_valid  in  1  memory returns one word this cycle.
- mem_data  in  16  returned word, qualified by mem_data_valid.
- mem_en  out  1  read request to memory this cycle.
- mem_addr  out  16  request address, qualified by mem_en.
- fill_busy  out  1  high while in FILL; fetch must stall.
- fill_done  out  1  one-cycle pulse in the cycle the last word and the metadata are written.
- metaIn  out  8  metadata word: {valid=1, lru=0, tag[5:0]}.
- dataIn  out  16  data word to cache; equals mem_data.
- blockEn  out  64  one-hot set select.
- wordEn  out  8  one-hot word select.
- metaWrite1, metaWrite2  out  1  metadata write strobe for way 1 / way 2.
- dataWrite1, dataWrite2  out  1  data write strobe for way 1 / way 2.

## Operation
- States:
  - IDLE: reset state.
  - FILL.
- Registers:
  - tag_q[5:0], set_q[5:0], way_q, all latched from miss_address/fill_way.
  - req_cnt[3:0] and rsp_cnt[3:0], both 0..8.
- IDLE -> FILL when miss_detected=1 at the clock edge. On that edge:
  - latch tag_q, set_q, way_q;
  - clear both counters.
- IDLE behaviour: every output is 0.
  - mem_data_valid is ignored.
  - metaIn and dataIn are driven 0.
- FILL, request side:
  - mem_en=1 while req_cnt<8.
  - mem_addr = {tag_q, set_q, req_cnt[2:0], 1'b0}.
  - req_cnt increments each cycle mem_en=1.
  - Memory accepts one request per cycle and never stalls.
- FILL, response side: in each cycle with mem_data_valid=1:
  - dataWrite(way_q+1)=1;
  - wordEn = one-hot of rsp_cnt[2:0];
  - blockEn = one-hot of set_q;
  - dataIn = mem_data;
  - rsp_cnt increments.
  - Responses arrive in request order; the controller does not depend on the actual latency.
- blockEn is driven as one-hot of set_q throughout FILL, and is 0 in IDLE.
- Last word (mem_data_valid with rsp_cnt=7), in the same cycle:
  - metaWrite(way_q+1)=1 and metaIn = {1'b1, 1'b0, tag_q};
  - fill_done=1;
  - next state is IDLE.
- Non-selected way strobes are always 0.
- miss_detected in FILL is ignored; fetch re-presents the miss after fill_done.
- Write strobes, wordEn, dataIn and fill_done are combinational from state, registers and mem_data_valid. mem_en, mem_addr and fill_busy depend on registers only.

## Timing
- Reset (rst=0 at an edge): next state IDLE, counters and latches 0, all outputs 0.
- Reset mid-FILL aborts the fill:
  - metadata is never written, so the partially filled line stays invalid;
  - memory responses still in flight after reset are ignored, because the controller is in IDLE.
- Cycle 0: miss_detected=1 in IDLE.
- Cycles 1–8: FILL with mem_en=1, addresses base+0, +2, …, +14.
- Data is written in whatever cycles mem_data_valid arrives. With the standard 4-cycle memory, words land in cycles 5–12 and fill_done pulses in cycle 12.
- Cycle 13: IDLE, fill_busy=0. A new miss may be accepted at the edge ending cycle 13.
- A response can coincide with an issue cycle (req_cnt<8 and valid together). Both actions happen in that cycle.
- Back-to-back misses: at most one fill in flight; no queueing.

## Test plan
- Basic fill, way 1:
  - Stimulus: miss_address=0x1A36, fill_way=0, 4-cycle memory returning 0xA000+i for word i.
  - Required response:
    - mem_addr sequence 0x1A30..0x1A3E;
    - blockEn bit 35 set;
    - dataWrite1 pulses ×8 with wordEn 0x01..0x80 and dataIn 0xA000..0xA007;
    - metaWrite1 with metaIn=0x86 on the 8th word;
    - fill_done once; dataWrite2/metaWrite2 never set.
- Way 2, set 63:
  - Stimulus: miss_address=0xFFF0, fill_way=1.
  - Required response: blockEn bit 63 set; only dataWrite2/metaWrite2 active; metaIn=0xBF.
- Irregular latency:
  - Stimulus: valid gaps of 0–3 cycles between words.
  - Required response: exactly 8 data writes in order; fill_done coincides with the 8th valid.
- Ignored inputs:
  - Stimulus: miss_detected re-asserted mid-fill with a different address; spurious mem_data_valid in IDLE.
  - Required response: latched address unchanged; no write strobes in IDLE.
- Reset mid-fill:
  - Stimulus: rst=0 after the 3rd data word.
  - Required response: next cycle IDLE and all outputs 0; later valids produce no writes; no metaWrite occurred.
- Back-to-back:
  - Stimulus: a second miss asserted the cycle after fill_done.
  - Required response: accepted immediately; second fill addresses correct.
